fft_r2_stage: RTL and testbench

FFT_R2_STAGE -- requirements
Module: fft_r2_stage

---
 rtl/fft_r2_stage.sv | 178 +++++++++++++++++
 tb/tb_fft_r2_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r2_stage.sv
// One radix-2 DIF butterfly stage over an N-point complex frame held in a local buffer.
// Latency: N load cycles, N/2 compute cycles (one butterfly per cycle), N unload cycles; done one cycle after the last output.
// Backpressure: in_ready only while loading; unload stalls and holds data while out_ready is low; compute never stalls.
module fft_r2_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int FRACTION   = 4,
  parameter int LOG2N      = 5,
  parameter int STAGE      = 0,
  parameter int SCALE      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [LOG2N-1:0]      out_index,
  output logic [LOG2N-2:0]      tw_addr,
  input  logic [DATA_WIDTH-1:0] tw_real,
  input  logic [DATA_WIDTH-1:0] tw_imag,
  output logic                  sat_flag
);
  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int LS   = LOG2N - 1 - STAGE;  // log2 of the butterfly span
  localparam int PW   = 2 * DATA_WIDTH + 1;
  localparam logic [LOG2N-1:0]     SPAN_MASK = LOG2N'((1 << LS) - 1);
  localparam logic [LOG2N-1:0]     SPAN      = LOG2N'(1 << LS);
  localparam logic signed [PW-1:0] MAXV      = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MINV      = -MAXV - PW'(1);
  localparam logic signed [PW-1:0] RND       = PW'(1 << (FRACTION - 1));

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

  state_t                        state;
  logic [LOG2N-1:0]              cnt;
  logic signed [DATA_WIDTH-1:0]  mem_re [N];
  logic signed [DATA_WIDTH-1:0]  mem_im [N];

  logic [LOG2N-1:0]              p, i0, i1;
  logic signed [DATA_WIDTH-1:0]  a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [DATA_WIDTH:0]    sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_WIDTH-1:0]  s_re, s_im, d_re, d_im, m_re, m_im;
  logic signed [PW-1:0]          dx_re, dx_im, wx_re, wx_im, pr_re, pr_im, sh_re, sh_im;
  logic                          sd_sat, mul_sat;

  function automatic logic signed [DATA_WIDTH-1:0] clip(input logic signed [PW-1:0] v);
    if (v > MAXV)      clip = MAXV[DATA_WIDTH-1:0];
    else if (v < MINV) clip = MINV[DATA_WIDTH-1:0];
    else               clip = v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic ovf(input logic signed [PW-1:0] v);
    ovf = (v > MAXV) || (v < MINV);
  endfunction

  // Butterfly j = cnt: pair (i0, i1) one span apart inside its block; twiddle exponent scales with the stage.
  assign p       = cnt & SPAN_MASK;
  assign i0      = cnt + (cnt & ~SPAN_MASK);
  assign i1      = i0 + SPAN;
  assign tw_addr = (state == COMPUTE) ? (LOG2N-1)'(p << STAGE) : '0;

  assign a_re   = mem_re[i0];
  assign a_im   = mem_im[i0];
  assign b_re   = mem_re[i1];
  assign b_im   = mem_im[i1];
  assign w_re   = tw_real;
  assign w_im   = tw_imag;
  assign sum_re = {a_re[DATA_WIDTH-1], a_re} + {b_re[DATA_WIDTH-1], b_re};
  assign sum_im = {a_im[DATA_WIDTH-1], a_im} + {b_im[DATA_WIDTH-1], b_im};
  assign dif_re = {a_re[DATA_WIDTH-1], a_re} - {b_re[DATA_WIDTH-1], b_re};
  assign dif_im = {a_im[DATA_WIDTH-1], a_im} - {b_im[DATA_WIDTH-1], b_im};

  // Narrow sum/difference back to sample width: halve when scaling, otherwise saturate.
  always_comb begin
    s_re   = clip(PW'(sum_re));
    s_im   = clip(PW'(sum_im));
    d_re   = clip(PW'(dif_re));
    d_im   = clip(PW'(dif_im));
    sd_sat = ovf(PW'(sum_re)) | ovf(PW'(sum_im)) | ovf(PW'(dif_re)) | ovf(PW'(dif_im));
    if (SCALE != 0) begin
      s_re   = sum_re[DATA_WIDTH:1];
      s_im   = sum_im[DATA_WIDTH:1];
      d_re   = dif_re[DATA_WIDTH:1];
      d_im   = dif_im[DATA_WIDTH:1];
      sd_sat = 1'b0;
    end
  end

  // Complex multiply of the difference by the twiddle, round to nearest, drop fraction, saturate.
  always_comb begin
    dx_re   = PW'(d_re);
    dx_im   = PW'(d_im);
    wx_re   = PW'(w_re);
    wx_im   = PW'(w_im);
    pr_re   = dx_re * wx_re - dx_im * wx_im;
    pr_im   = dx_re * wx_im + dx_im * wx_re;
    sh_re   = (pr_re + RND) >>> FRACTION;
    sh_im   = (pr_im + RND) >>> FRACTION;
    m_re    = clip(sh_re);
    m_im    = clip(sh_im);
    mul_sat = ovf(sh_re) | ovf(sh_im);
  end

  // Frame sequencing: load, in-place butterflies, ordered unload, one-cycle done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          cnt      <= '0;
          sat_flag <= 1'b0;
        end
        LOAD: if (in_valid) begin
          if (cnt == LOG2N'(N - 1)) begin
            state <= COMPUTE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + LOG2N'(1);
          end
        end
        COMPUTE: begin
          if (sd_sat || mul_sat) sat_flag <= 1'b1;
          if (cnt == LOG2N'(HALF - 1)) begin
            state <= UNLOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + LOG2N'(1);
          end
        end
        UNLOAD: if (out_ready) begin
          if (cnt == LOG2N'(N - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + LOG2N'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample buffer: filled in arrival order, then overwritten in place by each butterfly.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem_re[cnt] <= in_real;
      mem_im[cnt] <= in_imag;
    end else if (state == COMPUTE) begin
      mem_re[i0] <= s_re;
      mem_im[i0] <= s_im;
      mem_re[i1] <= m_re;
      mem_im[i1] <= m_im;
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign out_real  = (state == UNLOAD) ? mem_re[cnt] : '0;
  assign out_imag  = (state == UNLOAD) ? mem_im[cnt] : '0;
  assign out_index = (state == UNLOAD) ? cnt : '0;

endmodule

// File: tb/tb_fft_r2_stage.sv
// Bench for fft_r2_stage: three configurations (stage0, stage0 halved, stage1) driven in lockstep.
// Expected outputs come from a direct DIF butterfly model over integer arrays.
// Covers reset, saturation, span/twiddle order, output stall, mid-frame reset and ignored start.
module tb_fft_r2_stage;
  localparam int N    = 32;
  localparam int HALF = N / 2;

  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready;
  logic [7:0] in_real, in_imag;
  logic       busy_w [3], done_w [3], in_ready_w [3], out_valid_w [3], sat_w [3];
  logic [7:0] out_re_w [3], out_im_w [3], tw_r_w [3], tw_i_w [3];
  logic [4:0] out_idx_w [3];
  logic [3:0] tw_a_w [3];

  logic signed [7:0] tw_tab_re [16];
  logic signed [7:0] tw_tab_im [16];
  int in_re [N];
  int in_im [N];
  int exp_re [3][N];
  int exp_im [3][N];
  int exp_sat [3];
  int tw_exp0[$], tw_exp2[$], tw_got0[$], tw_got2[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft_r2_stage #(.DATA_WIDTH(8), .FRACTION(4), .LOG2N(5),
                   .STAGE(g == 2 ? 1 : 0), .SCALE(g == 1 ? 1 : 0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy_w[g]), .done(done_w[g]),
      .in_valid(in_valid), .in_ready(in_ready_w[g]), .in_real(in_real), .in_imag(in_imag),
      .out_valid(out_valid_w[g]), .out_ready(out_ready), .out_real(out_re_w[g]),
      .out_imag(out_im_w[g]), .out_index(out_idx_w[g]), .tw_addr(tw_a_w[g]),
      .tw_real(tw_r_w[g]), .tw_imag(tw_i_w[g]), .sat_flag(sat_w[g])
    );
    assign tw_r_w[g] = tw_tab_re[tw_a_w[g]];
    assign tw_i_w[g] = tw_tab_im[tw_a_w[g]];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clip8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference: for each block of 2S samples, pair element p with p+S using W_N^(p*2^stage).
  task automatic model(input int c);
    int st, sc, s, i0, i1, k, sr, si, dr, di, pr, pi;
    st = (c == 2) ? 1 : 0;
    sc = (c == 1) ? 1 : 0;
    s  = N >> (st + 1);
    exp_sat[c] = 0;
    if (c == 0) tw_exp0.delete();
    if (c == 2) tw_exp2.delete();
    for (int g = 0; g < N; g += 2 * s) begin
      for (int q = 0; q < s; q++) begin
        i0 = g + q;
        i1 = i0 + s;
        k  = q * (1 << st);
        if (c == 0) tw_exp0.push_back(k);
        if (c == 2) tw_exp2.push_back(k);
        sr = in_re[i0] + in_re[i1];
        si = in_im[i0] + in_im[i1];
        dr = in_re[i0] - in_re[i1];
        di = in_im[i0] - in_im[i1];
        if (sc != 0) begin
          sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
        end else begin
          if (clip8(sr) != sr || clip8(si) != si || clip8(dr) != dr || clip8(di) != di)
            exp_sat[c] = 1;
          sr = clip8(sr); si = clip8(si); dr = clip8(dr); di = clip8(di);
        end
        pr = (dr * int'(tw_tab_re[k]) - di * int'(tw_tab_im[k]) + 8) >>> 4;
        pi = (dr * int'(tw_tab_im[k]) + di * int'(tw_tab_re[k]) + 8) >>> 4;
        if (clip8(pr) != pr || clip8(pi) != pi) exp_sat[c] = 1;
        exp_re[c][i0] = sr;
        exp_im[c][i0] = si;
        exp_re[c][i1] = clip8(pr);
        exp_im[c][i1] = clip8(pi);
      end
    end
  endtask

  task automatic set_tw(input int rnd);
    for (int k = 0; k < 16; k++) begin
      tw_tab_re[k] = (rnd != 0) ? 8'(int'($urandom_range(0, 32)) - 16) : 8'sh10;
      tw_tab_im[k] = (rnd != 0) ? 8'(int'($urandom_range(0, 32)) - 16) : 8'sh00;
    end
  endtask

  task automatic run_frame(input int gaps_on, input int stall_at, input int abort_at);
    int i, k, guard, gap_cnt, stall_cnt, t0, cc;
    for (int c = 0; c < 3; c++) model(c);
    tw_got0.delete();
    tw_got2.delete();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    i = 0; guard = 0; gap_cnt = 0;
    while (i < N && guard < 2000) begin
      @(negedge clk);
      guard++;
      start    = (i == 3);
      in_valid = !(gaps_on != 0 && $urandom_range(0, 3) == 0);
      in_real  = 8'(in_re[i]);
      in_imag  = 8'(in_im[i]);
      if (in_ready_w[0] && !in_valid) gap_cnt++;
      if (in_ready_w[0] && in_valid) i++;
    end
    check("load_count", i, N);
    k = 0; guard = 0; stall_cnt = 0; cc = 0;
    while (k < N && guard < 2000) begin
      @(negedge clk);
      guard++;
      in_valid  = 1'b0;
      start     = (k == 10);
      out_ready = !(stall_at >= 0 && k == stall_at && stall_cnt < 3);
      if (!out_valid_w[0]) begin
        if (busy_w[0] && !in_ready_w[0]) begin
          tw_got0.push_back(int'(tw_a_w[0]));
          tw_got2.push_back(int'(tw_a_w[2]));
          if (cc == abort_at) begin
            reset = 1'b1;
            start = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            check("abort_busy", int'(busy_w[0]), 0);
            check("abort_in_ready", int'(in_ready_w[0]), 0);
            check("abort_out_valid", int'(out_valid_w[0]), 0);
            check("abort_sat", int'(sat_w[0]), 0);
            check("abort_tw_addr", int'(tw_a_w[2]), 0);
            @(negedge clk);
            check("abort_stays_idle", int'(busy_w[0]), 0);
            return;
          end
          cc++;
        end
        check("idle_out_zero", int'({out_re_w[0], out_im_w[0], out_idx_w[0]}), 0);
      end else begin
        for (int c = 0; c < 3; c++) begin
          check("out_valid", int'(out_valid_w[c]), 1);
          check("out_index", int'(out_idx_w[c]), k);
          check("out_real", int'($signed(out_re_w[c])), exp_re[c][k]);
          check("out_imag", int'($signed(out_im_w[c])), exp_im[c][k]);
        end
        if (out_ready) k++;
        else stall_cnt++;
      end
    end
    check("unload_count", k, N);
    out_ready = 1'b1;
    start = 1'b0;
    guard = 0;
    while (!done_w[0] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("done_time", cyc - t0, 2 * N + HALF + 1 + gap_cnt + stall_cnt);
    for (int c = 0; c < 3; c++) begin
      check("done_all", int'(done_w[c]), 1);
      check("sat_flag", int'(sat_w[c]), exp_sat[c]);
    end
    check("tw_len0", tw_got0.size(), tw_exp0.size());
    check("tw_len2", tw_got2.size(), tw_exp2.size());
    for (int j = 0; j < tw_exp0.size() && j < tw_got0.size(); j++) check("tw_addr0", tw_got0[j], tw_exp0[j]);
    for (int j = 0; j < tw_exp2.size() && j < tw_got2.size(); j++) check("tw_addr2", tw_got2[j], tw_exp2[j]);
    @(negedge clk);
    check("done_pulse", int'(done_w[0]), 0);
    check("idle_busy", int'(busy_w[0]), 0);
  endtask

  task automatic fill(input int mode);
    for (int q = 0; q < N; q++) begin
      case (mode)
        0: begin in_re[q] = 16;  in_im[q] = 0; end
        1: begin in_re[q] = 127; in_im[q] = 0; end
        2: begin in_re[q] = (q == 0 || q == 8) ? 16 : 0; in_im[q] = 0; end
        default: begin
          in_re[q] = int'($urandom_range(0, 255)) - 128;
          in_im[q] = int'($urandom_range(0, 255)) - 128;
        end
      endcase
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_real = '0; in_imag = '0;
    set_tw(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rst_busy", int'(busy_w[c]), 0);
      check("rst_done", int'(done_w[c]), 0);
      check("rst_in_ready", int'(in_ready_w[c]), 0);
      check("rst_out_valid", int'(out_valid_w[c]), 0);
      check("rst_sat", int'(sat_w[c]), 0);
      check("rst_outputs", int'({out_re_w[c], out_im_w[c], out_idx_w[c], tw_a_w[c]}), 0);
    end
    fill(0); run_frame(0, -1, -1);
    fill(1); run_frame(0, -1, -1);
    fill(2); run_frame(0, -1, -1);
    set_tw(1); fill(3); run_frame(0, 5, -1);
    fill(3); run_frame(0, -1, 7);
    set_tw(0); fill(0); run_frame(0, -1, -1);
    for (int r = 0; r < 4; r++) begin
      set_tw(1);
      fill(3);
      run_frame(1, int'($urandom_range(0, N - 1)), -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
